// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and data ports.
// Each access runs IDLE -> ISSUE -> (WAIT) -> RESP with registered strobes, read data and ready pulses.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_ready,
   output logic              inst_stall,
   input  logic              data_ren,
   input  logic              data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_ready,
   output logic              data_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t     state_reg;
   logic [3:0] cnt_reg;
   logic       last_data_reg;
   logic       win_data_reg;
   logic       data_req;
   logic       grant_data;
   logic       done_read;
   logic       done_any;

   assign data_req   = data_ren | data_wen;
   // On a conflict the port that did not win last time gets the RAM.
   assign grant_data = data_req & (~inst_req | ~last_data_reg);
   assign inst_stall = inst_req & ~inst_ready;
   assign data_stall = data_req & ~data_ready;

   assign done_read = ((state_reg == ISSUE) && !ram_we && (CNT_LOAD == 4'd0)) ||
                      ((state_reg == WAIT) && (cnt_reg == 4'd1));
   assign done_any  = done_read || ((state_reg == ISSUE) && ram_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         last_data_reg <= 1'b0;
         win_data_reg  <= 1'b0;
         ram_en        <= 1'b0;
         ram_we        <= 1'b0;
         ram_addr      <= '0;
         ram_wdata     <= '0;
         inst_rdata    <= '0;
         data_rdata    <= '0;
         inst_ready    <= 1'b0;
         data_ready    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (inst_req || data_req) begin
                  win_data_reg  <= grant_data;
                  last_data_reg <= grant_data;
                  ram_en        <= 1'b1;
                  ram_we        <= grant_data & data_wen;
                  ram_addr      <= grant_data ? data_addr : inst_addr;
                  if (grant_data)
                     ram_wdata <= data_wdata;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               ram_en  <= 1'b0;
               ram_we  <= 1'b0;
               cnt_reg <= CNT_LOAD;
               if (!done_any)
                  state_reg <= WAIT;
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
            end
            RESP: begin
               inst_ready <= 1'b0;
               data_ready <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase

         // Completion of ISSUE (write or LATENCY=1 read) or of the last WAIT cycle.
         if (done_any) begin
            state_reg <= RESP;
            if (win_data_reg)
               data_ready <= 1'b1;
            else
               inst_ready <= 1'b1;
         end
         if (done_read) begin
            if (win_data_reg)
               data_rdata <= ram_rdata;
            else
               inst_rdata <= ram_rdata;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-level transaction model plus directed scenarios,
// with a second LATENCY=1 instance for the short-latency path.
module tb_mem_port_arbiter;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic [31:0] inst_rdata;
   logic        inst_ready, inst_stall;
   logic        data_ren = 1'b0, data_wen = 1'b0;
   logic [31:0] data_addr = '0, data_wdata = '0;
   logic [31:0] data_rdata;
   logic        data_ready, data_stall;
   logic        ram_en, ram_we;
   logic [31:0] ram_addr, ram_wdata;
   logic [31:0] ram_rdata = '0;

   logic        b_inst_req = 1'b0;
   logic [31:0] b_inst_addr = '0;
   logic [31:0] b_inst_rdata, b_data_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
   logic        b_inst_ready, b_inst_stall, b_data_ready, b_data_stall, b_ram_en, b_ram_we;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
      .inst_ready(inst_ready), .inst_stall(inst_stall),
      .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_ready(data_ready), .data_stall(data_stall),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // LATENCY=1 instance: the RAM returns the word while the command is on the bus.
   assign b_ram_rdata = b_ram_en ? 32'hCAFE_F00D : 32'h0BAD_0BAD;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_rdata(b_inst_rdata),
      .inst_ready(b_inst_ready), .inst_stall(b_inst_stall),
      .data_ren(1'b0), .data_wen(1'b0), .data_addr(32'h0),
      .data_wdata(32'h0), .data_rdata(b_data_rdata),
      .data_ready(b_data_ready), .data_stall(b_data_stall),
      .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
      .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Backing store seen by the bench RAM, and the model's own view of memory.
   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] ram_val(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : (a ^ 32'h5A5A_0000);
   endfunction

   function automatic logic [31:0] ref_val(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
   endfunction

   // Bench RAM: read data is driven only in the cycle LAT-1 after the command cycle.
   initial begin
      bit          rd_pending;
      int          rd_off;
      logic [31:0] rd_addr;
      rd_pending = 0;
      rd_off     = 0;
      rd_addr    = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) rd_pending = 0;
         if (rd_pending) begin
            rd_off++;
            if (rd_off > LAT - 1) rd_pending = 0;
         end
         if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] = ram_wdata;
            else begin
               rd_pending = 1;
               rd_off     = 0;
               rd_addr    = ram_addr;
            end
         end
         ram_rdata = (rd_pending && rd_off == LAT - 1) ? ram_val(rd_addr) : (32'hBAD0_0000 ^ 32'(cyc));
      end
   end

   // Transaction model: one outstanding access with issue/ready cycles from the timing rules.
   logic        m_busy = 1'b0, m_data = 1'b0, m_we = 1'b0, m_last_data = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
   int          m_t_issue = 0, m_t_ready = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy      = 1'b0;
            m_last_data = 1'b0;
            m_irdata    = '0;
            m_drdata    = '0;
         end else begin
            if (m_busy) begin
               if (m_we && cyc == m_t_issue) ref_mem[m_addr] = m_wdata;
               if (!m_we && cyc == m_t_ready - 1) begin
                  if (m_data) m_drdata = ref_val(m_addr);
                  else        m_irdata = ref_val(m_addr);
               end
               if (cyc == m_t_ready) m_busy = 1'b0;
            end else if (inst_req || data_ren || data_wen) begin
               m_data      = (data_ren || data_wen) && (!inst_req || !m_last_data);
               m_last_data = m_data;
               m_we        = m_data && data_wen;
               m_addr      = m_data ? data_addr : inst_addr;
               m_wdata     = data_wdata;
               m_t_issue   = cyc + 1;
               m_t_ready   = m_we ? cyc + 2 : cyc + 1 + LAT;
               m_busy      = 1'b1;
            end
            cyc++;
         end
      end
   end

   int          last_en_cyc = -1;
   logic        last_en_we = 1'b0;
   logic [31:0] last_en_addr = '0;

   // Per-cycle compare of every output against the model.
   initial begin
      logic e_en, e_ir, e_dr;
      forever begin
         @(negedge clk);
         e_en = m_busy && cyc == m_t_issue;
         e_ir = m_busy && cyc == m_t_ready && !m_data;
         e_dr = m_busy && cyc == m_t_ready && m_data;
         chk("ram_en", 32'(ram_en), 32'(e_en));
         chk("ram_we", 32'(ram_we), 32'(e_en && m_we));
         if (e_en) begin
            chk("ram_addr", ram_addr, m_addr);
            if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
         end
         chk("inst_ready", 32'(inst_ready), 32'(e_ir));
         chk("data_ready", 32'(data_ready), 32'(e_dr));
         chk("inst_stall", 32'(inst_stall), 32'(inst_req && !e_ir));
         chk("data_stall", 32'(data_stall), 32'((data_ren || data_wen) && !e_dr));
         chk("inst_rdata", inst_rdata, m_irdata);
         chk("data_rdata", data_rdata, m_drdata);
         if (ram_en) begin
            last_en_cyc  = cyc;
            last_en_we   = ram_we;
            last_en_addr = ram_addr;
         end
      end
   end

   task automatic wait_rdy(input bit want_data, output int rc);
      rc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (want_data ? data_ready : inst_ready) begin
            rc = cyc;
            break;
         end
      end
      if (rc < 0) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int t, rc, last_rc;
      logic [3:0] ord;
      ram_mem[32'h40] = 32'h1234_5678;
      ref_mem[32'h40] = 32'h1234_5678;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Instruction read alone.
      @(posedge clk); #2;
      inst_req = 1'b1; inst_addr = 32'h40; t = cyc;
      wait_rdy(1'b0, rc);
      chk("t1_ready_lat", 32'(rc - t), 32'd3);
      chk("t1_en_lat", 32'(last_en_cyc - t), 32'd1);
      chk("t1_rdata", inst_rdata, 32'h1234_5678);
      chk("t1_stall_at_ready", 32'(inst_stall), 32'd0);
      @(posedge clk); #2 inst_req = 1'b0;

      // Data write alone, then read back through both ports.
      @(posedge clk); #2;
      data_wen = 1'b1; data_addr = 32'h80; data_wdata = 32'hDEAD_BEEF; t = cyc;
      wait_rdy(1'b1, rc);
      chk("t2_ready_lat", 32'(rc - t), 32'd2);
      chk("t2_en_lat", 32'(last_en_cyc - t), 32'd1);
      chk("t2_en_we", 32'(last_en_we), 32'd1);
      chk("t2_en_addr", last_en_addr, 32'h80);
      chk("t2_inst_rdata_kept", inst_rdata, 32'h1234_5678);
      @(posedge clk); #2 data_wen = 1'b0;
      @(posedge clk); #2;
      data_ren = 1'b1; t = cyc;
      wait_rdy(1'b1, rc);
      chk("t2_rd_lat", 32'(rc - t), 32'd3);
      chk("t2_rd_data", data_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #2 data_ren = 1'b0;
      @(posedge clk); #2;
      inst_req = 1'b1; inst_addr = 32'h80;
      wait_rdy(1'b0, rc);
      chk("t2_inst_rd", inst_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #2 inst_req = 1'b0;

      // Conflict after reset, both held: D, I, D, I.
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h100;
      data_ren = 1'b1; data_addr = 32'h200; t = cyc;
      ord = 4'b0; last_rc = 0;
      for (int k = 0; k < 4; k++) begin
         rc = -1;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inst_ready || data_ready) begin
               rc = cyc;
               break;
            end
         end
         if (rc < 0) chk("t3_timeout", 32'd0, 32'd1);
         ord = {ord[2:0], data_ready};
         if (k == 0) chk("t3_first_lat", 32'(rc - t), 32'd3);
         last_rc = rc;
      end
      chk("t3_order", 32'(ord), 32'b1010);
      chk("t3_total_span", 32'(last_rc - t), 32'd15);
      chk("t3_inst_rdata", inst_rdata, 32'h5A5A_0100);
      chk("t3_data_rdata", data_rdata, 32'h5A5A_0200);
      @(posedge clk); #2;
      inst_req = 1'b0; data_ren = 1'b0;

      // Read and write together act as a write.
      @(posedge clk); #2;
      data_ren = 1'b1; data_wen = 1'b1; data_addr = 32'h84; data_wdata = 32'h0BAD_F00D; t = cyc;
      wait_rdy(1'b1, rc);
      chk("t4_lat", 32'(rc - t), 32'd2);
      chk("t4_en_we", 32'(last_en_we), 32'd1);
      chk("t4_rdata_kept", data_rdata, 32'h5A5A_0200);
      @(posedge clk); #2;
      data_ren = 1'b0; data_wen = 1'b0;
      @(posedge clk); #2;
      inst_req = 1'b1; inst_addr = 32'h84;
      wait_rdy(1'b0, rc);
      chk("t4_written", inst_rdata, 32'h0BAD_F00D);
      @(posedge clk); #2 inst_req = 1'b0;

      // Reset during WAIT of an instruction read, request held across it.
      @(posedge clk); #2;
      inst_req = 1'b1; inst_addr = 32'h44;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ram_en", 32'(ram_en), 32'd0);
      chk("t5_rst_ready", 32'(inst_ready), 32'd0);
      chk("t5_rst_rdata", inst_rdata, 32'd0);
      chk("t5_rst_stall", 32'(inst_stall), 32'd1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      t = cyc;
      wait_rdy(1'b0, rc);
      chk("t5_restart_lat", 32'(rc - t), 32'd3);
      chk("t5_rdata", inst_rdata, 32'h5A5A_0044);
      @(posedge clk); #2 inst_req = 1'b0;

      // LATENCY=1 instance: instruction read.
      @(posedge clk); #2;
      b_inst_req = 1'b1; b_inst_addr = 32'h60; t = cyc;
      last_rc = -1; rc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (b_ram_en) begin
            last_rc = cyc;
            chk("t6_addr", b_ram_addr, 32'h60);
            chk("t6_we", 32'(b_ram_we), 32'd0);
         end
         if (b_inst_ready) begin
            rc = cyc;
            break;
         end
      end
      chk("t6_en_lat", 32'(last_rc - t), 32'd1);
      chk("t6_ready_lat", 32'(rc - t), 32'd2);
      chk("t6_rdata", b_inst_rdata, 32'hCAFE_F00D);
      chk("t6_stall", 32'(b_inst_stall), 32'd0);
      chk("t6_data_side", {b_data_rdata[29:0], b_data_ready, b_data_stall}, 32'd0);
      chk("t6_wdata", b_ram_wdata, 32'd0);
      @(posedge clk); #2 b_inst_req = 1'b0;

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the pipeline's instruction-fetch port and its MEM-stage data port.
- Sits between the datapath (inst_ren/inst_addr and mem_ren/mem_wen/mem_addr/mem_dout) and the unified memory.
- Sequences each access through a small FSM and returns one-cycle ready pulses with registered read data.
- Drives per-port stall flags that the pipeline controller uses to drop if_en and mem_en until the access completes.

Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width.
- LATENCY, 2, clock edges from the RAM enable cycle to valid ram_rdata. Legal range is 1..15.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction read request; held stable until inst_ready.
- inst_addr  in  ADDR_W  instruction address.
- inst_rdata  out  DATA_W  registered instruction word.
- inst_ready  out  1  one-cycle completion pulse.
- inst_stall  out  1  inst_req & ~inst_ready.
- data_ren  in  1  data read request; held until data_ready.
- data_wen  in  1  data write request; held until data_ready.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  registered load data.
- data_ready  out  1  one-cycle completion pulse.
- data_stall  out  1  (data_ren|data_wen) & ~data_ready.
- ram_en  out  1  RAM command strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid LATENCY edges after the ram_en cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, last_grant=INST.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - inst_rdata=0, data_rdata=0, inst_ready=0, data_ready=0.
  - Stall outputs stay combinational, so during reset they equal the raw requests.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one port requesting: grant it.
  - Both requesting: grant the port not equal to last_grant. After reset, data therefore wins the first conflict.
  - On the grant edge: latch winner, address, and we = data_wen (data_ren&data_wen together is treated as a write); update last_grant; go to ISSUE.
- ISSUE: exactly one cycle.
  - ram_en=1; ram_we/ram_addr/ram_wdata are the latched values.
  - Write: next state is RESP.
  - Read: cnt=LATENCY-1; next state is WAIT if cnt>0, else RESP with ram_rdata captured on this edge when LATENCY=1.
- WAIT:
  - ram_en=0; cnt decrements each cycle.
  - On the edge where cnt reaches 0: capture ram_rdata into the winner's rdata register, go to RESP.
- RESP: exactly one cycle.
  - Winner's ready=1. Read data is valid on the winner's rdata register.
  - The other port's rdata register is untouched.
  - Next state is always IDLE. The requester deasserts or changes its request in the IDLE cycle, so there is no double issue.
- Latency, with the request sampled in IDLE at cycle T:
  - Read: ram_en at T+1, ready at T+1+LATENCY.
  - Write: ram_en at T+1, ready at T+2.
  - The next request can be sampled at ready+1.
- ram_en is high only in ISSUE. ram_we is 0 outside ISSUE.
- A request that drops before being granted is ignored.
- Changing address or data while granted is a protocol violation: the latched values are used.
- Reset mid-access: the in-flight RAM read is discarded, no ready pulse is produced, and rdata clears.
- inst_ready and data_ready are never high in the same cycle.
- No request is starved: with both ports continuously requesting, grants alternate.

Test Plan:
- LATENCY=2. inst_req at 0x40 alone, RAM returns 0x1234_5678 → ram_en at T+1, inst_ready and inst_rdata=0x12345678 at T+3; inst_stall high T..T+2, low at T+3.
- Data write only, 0x80 ← 0xDEAD_BEEF → ram_en=ram_we=1 at T+1 with addr 0x80; data_ready at T+2; inst_rdata unchanged.
- Both ports request first after reset → data granted first, then inst. Both held continuously → grant order D, I, D, I over four accesses.
- data_ren=data_wen=1 → a write is performed (ram_we=1), and data_rdata keeps its previous value.
- rst_n pulsed low during WAIT of an inst read → immediately IDLE, ram_en=0, no inst_ready. After release with the request still held, the access restarts and completes 3 cycles after the restart sample.
- LATENCY=1 build: inst read → ram_en at T+1, ready at T+2, with the captured value equal to ram_rdata presented during the ISSUE-following edge.
